// File: rtl/arbitro_pkg.sv
// -----------------------------------------------------------------------------
// arbitro_pkg
// Shared constants and types for the weighted round-robin arbiter
// (arbitro_wrr), its bus interface and its rotating-pick helper.
//
// Contents:
//   NUM_CH_DEF / DATA_W_DEF / CLASS_LSB_DEF / WEIGHT_W_DEF : parameter defaults
//   DROP_W         : width of the saturating drop counter
//   arb_action_e   : what the arbiter does in the current cycle (debug view)
//   sat_inc        : saturating increment for the drop counter
// -----------------------------------------------------------------------------
package arbitro_pkg;

    localparam int NUM_CH_DEF    = 4;
    localparam int DATA_W_DEF    = 12;
    localparam int CLASS_LSB_DEF = 8;
    localparam int WEIGHT_W_DEF  = 3;
    localparam int DROP_W        = 8;

    // Per-cycle decision of the arbiter. Exposed on the bus so checkers can
    // see whether a cycle was a stall, a reload bubble, a pop or idle.
    typedef enum logic [1:0] {
        ACT_IDLE   = 2'd0,
        ACT_STALL  = 2'd1,
        ACT_RELOAD = 2'd2,
        ACT_POP    = 2'd3
    } arb_action_e;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/arbitro_wrr_if.sv
// -----------------------------------------------------------------------------
// arbitro_wrr_if
// Bundles every non-clock/reset signal of arbitro_wrr.
//
// Handshake semantics: there is no ready/valid backpressure on this block.
// pop[i]/push[i] are single-cycle strobes, valid in the cycle they are high;
// demux_in is consumed when demux_valid=1 in a cycle where the arbiter is not
// stalled and the class is in range, otherwise it is counted in drop_cnt.
// grant_id is meaningful only while grant_valid=1 and names the channel that
// was popped in the previous cycle.
//
// Signals:
//   active           in  : block enable, 0 stalls everything
//   weights          in  : per-channel weight, channel i at [i*WEIGHT_W +: WEIGHT_W]
//   empty_fifo       in  : input FIFO empty flags
//   almost_full_fifo in  : downstream almost-full flags, any set stalls
//   demux_in         in  : incoming word, class at [CLASS_LSB +: CW]
//   demux_valid      in  : demux_in valid this cycle
//   pop              out : one-hot/zero pop strobes
//   push             out : one-hot/zero push strobes
//   grant_id         out : channel popped last cycle
//   grant_valid      out : grant_id meaningful
//   drop_cnt         out : saturating count of refused valid words
//   dbg_action       out : current-cycle arbiter decision
// Modports: master (drives the inputs), slave (the arbiter).
// -----------------------------------------------------------------------------
interface arbitro_wrr_if
    import arbitro_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WEIGHT_W = WEIGHT_W_DEF
);
    localparam int CW = $clog2(NUM_CH);

    logic                         active;
    logic [NUM_CH*WEIGHT_W-1:0]   weights;
    logic [NUM_CH-1:0]            empty_fifo;
    logic [NUM_CH-1:0]            almost_full_fifo;
    logic [DATA_W-1:0]            demux_in;
    logic                         demux_valid;
    logic [NUM_CH-1:0]            pop;
    logic [NUM_CH-1:0]            push;
    logic [CW-1:0]                grant_id;
    logic                         grant_valid;
    logic [DROP_W-1:0]            drop_cnt;
    arb_action_e                  dbg_action;

    modport master (
        output active, weights, empty_fifo, almost_full_fifo, demux_in, demux_valid,
        input  pop, push, grant_id, grant_valid, drop_cnt, dbg_action
    );

    modport slave (
        input  active, weights, empty_fifo, almost_full_fifo, demux_in, demux_valid,
        output pop, push, grant_id, grant_valid, drop_cnt, dbg_action
    );

endinterface

// File: rtl/arbitro_wrr_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Rotating first-set search: starting at ptr_i and moving upward modulo N,
// returns the first index whose request bit is set.
//
// Ports:
//   req_i   in  [N-1:0]  request vector
//   ptr_i   in  [IW-1:0] search start (must be < N)
//   found_o out          some request bit is set
//   idx_o   out [IW-1:0] index of the first set bit at/after ptr_i
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    // Rotated view: bit k corresponds to channel (ptr_i + k) mod N.
    logic [N-1:0] req_rot;
    logic [IW:0]  sum;

    always_comb begin
        req_rot = N'({req_i, req_i} >> ptr_i);
        found_o = 1'b0;
        idx_o   = '0;
        sum     = '0;
        for (int k = 0; k < N; k++) begin
            if (!found_o && req_rot[k]) begin
                found_o = 1'b1;
                // One extra bit keeps ptr+k from overflowing before the wrap.
                sum = {1'b0, ptr_i} + (IW+1)'(k);
                if (sum >= (IW+1)'(N)) begin
                    sum = sum - (IW+1)'(N);
                end
                idx_o = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/arbitro_wrr.sv
// -----------------------------------------------------------------------------
// arbitro_wrr
// Weighted round-robin pop arbiter over NUM_CH input FIFOs plus a class-based
// push demux with a saturating drop counter.
//
// Each channel owns a credit register. A pop of channel i spends one credit;
// the pointer stays on i while it still has credit, otherwise it moves on.
// When nothing is eligible but some non-empty channel has a nonzero weight,
// one bubble cycle reloads every credit from the weights input.
//
// Ports:
//   clk    in : rising-edge clock
//   reset  in : asynchronous active-high reset
//   bus       : arbitro_wrr_if.slave (see interface header for signal list)
// -----------------------------------------------------------------------------
module arbitro_wrr
    import arbitro_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CLASS_LSB = CLASS_LSB_DEF,
    parameter int WEIGHT_W  = WEIGHT_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    arbitro_wrr_if.slave bus
);

    localparam int CW = $clog2(NUM_CH);

    // State
    logic [WEIGHT_W-1:0] credit_q [NUM_CH];
    logic [WEIGHT_W-1:0] credit_d [NUM_CH];
    logic [CW-1:0]       ptr_q,         ptr_d;
    logic [CW-1:0]       grant_id_q,    grant_id_d;
    logic                grant_valid_q, grant_valid_d;
    logic [DROP_W-1:0]   drop_cnt_q,    drop_cnt_d;

    // Combinational decode
    logic                stall;
    logic [NUM_CH-1:0]   eligible;
    logic [NUM_CH-1:0]   weighted;
    logic                pick_found;
    logic [CW-1:0]       pick_idx;
    logic [WEIGHT_W-1:0] credit_left;
    logic [CW-1:0]       next_idx;
    logic [CW-1:0]       cls;
    logic                cls_ok;
    logic [NUM_CH-1:0]   pop_vec;
    logic [NUM_CH-1:0]   push_vec;
    arb_action_e         action;

    always_comb begin
        stall    = !bus.active | (|bus.almost_full_fifo);
        eligible = '0;
        weighted = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            eligible[i] = !bus.empty_fifo[i] && (credit_q[i] != '0);
            weighted[i] = !bus.empty_fifo[i] &&
                          (bus.weights[i*WEIGHT_W +: WEIGHT_W] != '0);
        end
    end

    rr_pick #(
        .N  (NUM_CH),
        .IW (CW)
    ) u_pick (
        .req_i   (eligible),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // A reload only happens when it can lead to a pop; with every non-empty
    // channel disabled (or everything empty) the arbiter just idles.
    always_comb begin
        action = ACT_IDLE;
        if (stall) begin
            action = ACT_STALL;
        end else if (pick_found) begin
            action = ACT_POP;
        end else if (|weighted) begin
            action = ACT_RELOAD;
        end
    end

    always_comb begin
        cls      = bus.demux_in[CLASS_LSB +: CW];
        cls_ok   = (int'(cls) < NUM_CH);
        pop_vec  = '0;
        push_vec = '0;
        if (!reset && action == ACT_POP) begin
            pop_vec = NUM_CH'(1) << pick_idx;
        end
        if (!reset && bus.demux_valid && !stall && cls_ok) begin
            push_vec = NUM_CH'(1) << cls;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            credit_d[i] = credit_q[i];
        end
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = 1'b0;
        drop_cnt_d    = drop_cnt_q;
        credit_left   = credit_q[pick_idx] - WEIGHT_W'(1);
        next_idx      = (pick_idx == CW'(NUM_CH-1)) ? '0 : pick_idx + CW'(1);

        case (action)
            ACT_POP: begin
                credit_d[pick_idx] = credit_left;
                // Stay on the channel while it has budget left this round.
                ptr_d         = (credit_left != '0) ? pick_idx : next_idx;
                grant_id_d    = pick_idx;
                grant_valid_d = 1'b1;
            end
            ACT_RELOAD: begin
                // Weights are sampled only here, so mid-round weight changes
                // never disturb credits already handed out.
                for (int i = 0; i < NUM_CH; i++) begin
                    credit_d[i] = bus.weights[i*WEIGHT_W +: WEIGHT_W];
                end
            end
            default: begin
            end
        endcase

        if (bus.demux_valid && (push_vec == '0)) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                credit_q[i] <= '0;
            end
            ptr_q         <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                credit_q[i] <= credit_d[i];
            end
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign bus.pop         = pop_vec;
    assign bus.push        = push_vec;
    assign bus.grant_id    = grant_id_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.drop_cnt    = drop_cnt_q;
    assign bus.dbg_action  = action;

endmodule

// File: tb/tb_arbitro_wrr.sv
// -----------------------------------------------------------------------------
// tb_arbitro_wrr
// Bench for arbitro_wrr: a 4-channel instance for arbitration scenarios and a
// 3-channel instance for the out-of-range class / drop counter behaviour.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_arbitro_wrr;
    import arbitro_pkg::*;

    localparam int N4 = 4;
    localparam int N3 = 3;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [3:0] exp_q[$];
    logic [3:0] af_q[$];
    logic [3:0] em_q[$];

    arbitro_wrr_if #(.NUM_CH(N4), .DATA_W(12), .WEIGHT_W(3)) if4 ();
    arbitro_wrr_if #(.NUM_CH(N3), .DATA_W(12), .WEIGHT_W(3)) if3 ();

    arbitro_wrr #(.NUM_CH(N4), .DATA_W(12), .CLASS_LSB(8), .WEIGHT_W(3)) u4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4.slave)
    );

    arbitro_wrr #(.NUM_CH(N3), .DATA_W(12), .CLASS_LSB(8), .WEIGHT_W(3)) u3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3.slave)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- driver helpers ----------------
    function automatic logic [1:0] oh_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
        return r;
    endfunction

    task automatic set_w4(input int w0, input int w1, input int w2, input int w3);
        if4.weights = {3'(w3), 3'(w2), 3'(w1), 3'(w0)};
    endtask

    task automatic push_step(input logic [3:0] e, input logic [3:0] af,
                             input logic [3:0] em, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(e);
            af_q.push_back(af);
            em_q.push_back(em);
        end
    endtask

    task automatic clear_queues();
        exp_q.delete();
        af_q.delete();
        em_q.delete();
    endtask

    // Leaves the bench at a falling edge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        if4.active = 1'b1; if4.empty_fifo = 4'b0000; set_w4(4, 3, 2, 1);
        if4.demux_valid = 1'b1; if4.demux_in = 12'h100;
        if3.active = 1'b1; if3.demux_valid = 1'b1; if3.demux_in = 12'h000;
        #1;
        total++; if (if4.pop !== 4'b0000) begin bad++; $display("FAIL reset_pop: got %b want 0000", if4.pop); end
        total++; if (if4.push !== 4'b0000) begin bad++; $display("FAIL reset_push: got %b want 0000", if4.push); end
        total++; if (if4.grant_valid !== 1'b0) begin bad++; $display("FAIL reset_gv: got %b want 0", if4.grant_valid); end
        total++; if (if4.grant_id !== 2'd0) begin bad++; $display("FAIL reset_gid: got %0d want 0", if4.grant_id); end
        total++; if (if4.drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", if4.drop_cnt); end
        total++; if (if3.push !== 3'b000) begin bad++; $display("FAIL reset_push3: got %b want 000", if3.push); end
        @(negedge clk);
        #1;
        total++; if (if4.drop_cnt !== 8'd0 || if3.drop_cnt !== 8'd0) begin
            bad++; $display("FAIL reset_drop_hold: got %0d/%0d want 0/0", if4.drop_cnt, if3.drop_cnt);
        end
        @(negedge clk);
        if4.demux_valid = 1'b0; if3.demux_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_weighted_round();
        logic [3:0] e; logic gv; logic [1:0] gid; int step;
        do_reset();
        set_w4(4, 3, 2, 1);
        clear_queues();
        for (int r = 0; r < 2; r++) begin
            push_step(4'b0000, 4'b0, 4'b0, 1);
            push_step(4'b0001, 4'b0, 4'b0, 4);
            push_step(4'b0010, 4'b0, 4'b0, 3);
            push_step(4'b0100, 4'b0, 4'b0, 2);
            push_step(4'b1000, 4'b0, 4'b0, 1);
        end
        push_step(4'b0000, 4'b0, 4'b0, 1);
        gv = 1'b0; gid = 2'd0; step = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if4.almost_full_fifo = af_q.pop_front();
            if4.empty_fifo = em_q.pop_front();
            #1;
            total++; if (if4.pop !== e) begin bad++; $display("FAIL round_pop step %0d: got %b want %b", step, if4.pop, e); end
            total++; if (if4.grant_valid !== gv || (gv && if4.grant_id !== gid)) begin
                bad++; $display("FAIL round_grant step %0d: got v=%b id=%0d want v=%b id=%0d", step, if4.grant_valid, if4.grant_id, gv, gid);
            end
            gv = (e != 4'b0000);
            if (gv) gid = oh_idx(e);
            step++;
            @(negedge clk);
        end
    endtask

    task automatic test_stall_hold();
        logic [3:0] e; logic gv; logic [1:0] gid; int step;
        do_reset();
        set_w4(4, 3, 2, 1);
        clear_queues();
        push_step(4'b0000, 4'b0000, 4'b0, 1);
        push_step(4'b0001, 4'b0000, 4'b0, 4);
        push_step(4'b0010, 4'b0000, 4'b0, 2);
        push_step(4'b0000, 4'b0010, 4'b0, 3);
        push_step(4'b0010, 4'b0000, 4'b0, 1);
        push_step(4'b0100, 4'b0000, 4'b0, 2);
        push_step(4'b1000, 4'b0000, 4'b0, 1);
        push_step(4'b0000, 4'b0000, 4'b0, 1);
        push_step(4'b0001, 4'b0000, 4'b0, 1);
        gv = 1'b0; gid = 2'd0; step = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if4.almost_full_fifo = af_q.pop_front();
            if4.empty_fifo = em_q.pop_front();
            #1;
            total++; if (if4.pop !== e) begin bad++; $display("FAIL stall_pop step %0d: got %b want %b", step, if4.pop, e); end
            total++; if (if4.grant_valid !== gv || (gv && if4.grant_id !== gid)) begin
                bad++; $display("FAIL stall_grant step %0d: got v=%b id=%0d want v=%b id=%0d", step, if4.grant_valid, if4.grant_id, gv, gid);
            end
            gv = (e != 4'b0000);
            if (gv) gid = oh_idx(e);
            step++;
            @(negedge clk);
        end
        if4.almost_full_fifo = 4'b0000;
    endtask

    // ch1 runs dry after one pop; its two leftover credits are spent after the
    // pointer comes back round, and the reload bubble keeps the pointer on ch2.
    task automatic test_empty_refill();
        logic [3:0] e; int step;
        do_reset();
        set_w4(4, 3, 2, 1);
        clear_queues();
        push_step(4'b0000, 4'b0, 4'b0000, 1);
        push_step(4'b0001, 4'b0, 4'b0000, 4);
        push_step(4'b0010, 4'b0, 4'b0000, 1);
        push_step(4'b0100, 4'b0, 4'b0010, 1);
        push_step(4'b0100, 4'b0, 4'b0000, 1);
        push_step(4'b1000, 4'b0, 4'b0000, 1);
        push_step(4'b0010, 4'b0, 4'b0000, 2);
        push_step(4'b0000, 4'b0, 4'b0000, 1);
        push_step(4'b0100, 4'b0, 4'b0000, 2);
        push_step(4'b1000, 4'b0, 4'b0000, 1);
        push_step(4'b0001, 4'b0, 4'b0000, 1);
        step = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if4.almost_full_fifo = af_q.pop_front();
            if4.empty_fifo = em_q.pop_front();
            #1;
            total++; if (if4.pop !== e) begin bad++; $display("FAIL refill_pop step %0d: got %b want %b", step, if4.pop, e); end
            step++;
            @(negedge clk);
        end
        if4.empty_fifo = 4'b0000;
    endtask

    task automatic test_zero_weights();
        logic [3:0] e; int step;
        do_reset();
        set_w4(0, 2, 0, 2);
        clear_queues();
        for (int r = 0; r < 2; r++) begin
            push_step(4'b0000, 4'b0, 4'b0000, 1);
            push_step(4'b0010, 4'b0, 4'b0000, 2);
            push_step(4'b1000, 4'b0, 4'b0000, 2);
        end
        push_step(4'b0000, 4'b0, 4'b0000, 1);
        // only zero-weight channels have data: nothing moves
        push_step(4'b0000, 4'b0, 4'b1010, 3);
        // everything empty: nothing moves
        push_step(4'b0000, 4'b0, 4'b1111, 2);
        // credits loaded before the idle stretch are still there
        push_step(4'b0010, 4'b0, 4'b0000, 2);
        push_step(4'b1000, 4'b0, 4'b0000, 1);
        step = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if4.almost_full_fifo = af_q.pop_front();
            if4.empty_fifo = em_q.pop_front();
            #1;
            total++; if (if4.pop !== e) begin bad++; $display("FAIL zerow_pop step %0d: got %b want %b", step, if4.pop, e); end
            step++;
            @(negedge clk);
        end
        if4.empty_fifo = 4'b0000;
    endtask

    task automatic test_async_reset();
        logic [3:0] e; int step;
        do_reset();
        set_w4(4, 3, 2, 1);
        if4.empty_fifo = 4'b0000; if4.almost_full_fifo = 4'b0000;
        // bubble
        #1;
        total++; if (if4.pop !== 4'b0000) begin bad++; $display("FAIL areset_bubble0: got %b want 0000", if4.pop); end
        @(negedge clk);
        // stalled valid word: refused, counted
        if4.almost_full_fifo = 4'b0001; if4.demux_valid = 1'b1; if4.demux_in = 12'h200;
        #1;
        total++; if (if4.pop !== 4'b0000 || if4.push !== 4'b0000) begin
            bad++; $display("FAIL areset_stall: got pop=%b push=%b want 0000/0000", if4.pop, if4.push);
        end
        @(negedge clk);
        if4.almost_full_fifo = 4'b0000; if4.demux_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            e = (i < 4) ? 4'b0001 : 4'b0010;
            #1;
            total++; if (if4.pop !== e) begin bad++; $display("FAIL areset_pre_pop %0d: got %b want %b", i, if4.pop, e); end
            @(negedge clk);
        end
        // second ch1 pop in flight
        #1;
        total++; if (if4.pop !== 4'b0010 || if4.grant_valid !== 1'b1 || if4.grant_id !== 2'd1 || if4.drop_cnt !== 8'd1) begin
            bad++; $display("FAIL areset_before: got pop=%b gv=%b gid=%0d drop=%0d want 0010/1/1/1", if4.pop, if4.grant_valid, if4.grant_id, if4.drop_cnt);
        end
        #2;
        reset = 1'b1;
        #1;
        total++; if (if4.pop !== 4'b0000 || if4.grant_valid !== 1'b0 || if4.grant_id !== 2'd0 || if4.drop_cnt !== 8'd0) begin
            bad++; $display("FAIL areset_now: got pop=%b gv=%b gid=%0d drop=%0d want 0000/0/0/0", if4.pop, if4.grant_valid, if4.grant_id, if4.drop_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        clear_queues();
        push_step(4'b0000, 4'b0, 4'b0, 1);
        push_step(4'b0001, 4'b0, 4'b0, 4);
        push_step(4'b0010, 4'b0, 4'b0, 3);
        step = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if4.almost_full_fifo = af_q.pop_front();
            if4.empty_fifo = em_q.pop_front();
            #1;
            total++; if (if4.pop !== e) begin bad++; $display("FAIL areset_post step %0d: got %b want %b", step, if4.pop, e); end
            step++;
            @(negedge clk);
        end
    endtask

    task automatic test_drop_class();
        int exp_drop; int cls; logic [2:0] e_push; logic [11:0] w;
        int classes[6];
        classes = '{3, 0, 3, 1, 2, 3};
        do_reset();
        if3.active = 1'b1; if3.almost_full_fifo = 3'b000; if3.empty_fifo = 3'b111;
        if3.weights = {3'd1, 3'd1, 3'd1};
        exp_drop = 0;
        for (int i = 0; i < 16; i++) begin
            cls = (i < 6) ? classes[i] : $urandom_range(0, 3);
            w = 12'($urandom);
            w[9:8] = 2'(cls);
            if3.demux_in = w; if3.demux_valid = 1'b1;
            #1;
            e_push = (cls < N3) ? 3'(1 << cls) : 3'b000;
            total++; if (if3.push !== e_push) begin bad++; $display("FAIL class_push cls=%0d: got %b want %b", cls, if3.push, e_push); end
            total++; if (if3.drop_cnt !== 8'(exp_drop)) begin bad++; $display("FAIL class_drop cls=%0d: got %0d want %0d", cls, if3.drop_cnt, exp_drop); end
            total++; if (if3.pop !== 3'b000) begin bad++; $display("FAIL class_pop: got %b want 000", if3.pop); end
            if (e_push == 3'b000) exp_drop++;
            @(negedge clk);
        end
        // stalled valids, some via active=0, some via almost-full
        for (int i = 0; i < 300; i++) begin
            if3.active = (i % 2 == 0) ? 1'b0 : 1'b1;
            if3.almost_full_fifo = (i % 2 == 0) ? 3'b000 : 3'(1 << $urandom_range(0, 2));
            if3.demux_in = 12'($urandom); if3.demux_in[9:8] = 2'($urandom_range(0, 2));
            if3.demux_valid = 1'b1;
            #1;
            total++; if (if3.push !== 3'b000) begin bad++; $display("FAIL stall_push %0d: got %b want 000", i, if3.push); end
            if (exp_drop < 255) exp_drop++;
            @(negedge clk);
        end
        if3.demux_valid = 1'b0; if3.active = 1'b1; if3.almost_full_fifo = 3'b000;
        #1;
        total++; if (if3.drop_cnt !== 8'(exp_drop) || if3.drop_cnt !== 8'd255) begin
            bad++; $display("FAIL drop_sat: got %0d want 255 (model %0d)", if3.drop_cnt, exp_drop);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int m_cred[4]; int m_ptr; logic m_gv; logic [1:0] m_gid; int m_drop;
        int w[4]; logic stall; logic [3:0] e_pop; logic [3:0] e_push; int pick; int c; bit any_w;
        do_reset();
        for (int i = 0; i < 4; i++) begin m_cred[i] = 0; w[i] = 0; end
        m_ptr = 0; m_gv = 1'b0; m_gid = 2'd0; m_drop = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 45 == 0) begin
                for (int i = 0; i < 4; i++) begin
                    w[i] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 7);
                end
                set_w4(w[0], w[1], w[2], w[3]);
            end
            if4.empty_fifo = ($urandom_range(0, 19) == 0) ? 4'b1111 : 4'($urandom) & 4'($urandom);
            if4.almost_full_fifo = ($urandom_range(0, 9) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
            if4.active = ($urandom_range(0, 9) != 0);
            if4.demux_valid = 1'($urandom_range(0, 1));
            if4.demux_in = 12'($urandom);
            #1;
            stall = !if4.active || (if4.almost_full_fifo != 4'b0000);
            pick = -1;
            if (!stall) begin
                for (int k = 0; k < 4; k++) begin
                    c = (m_ptr + k) % 4;
                    if (pick < 0 && !if4.empty_fifo[c] && m_cred[c] > 0) pick = c;
                end
            end
            e_pop  = (pick >= 0) ? 4'(1 << pick) : 4'b0000;
            e_push = (if4.demux_valid && !stall) ? 4'(1 << int'(if4.demux_in[9:8])) : 4'b0000;
            total++; if (if4.pop !== e_pop) begin bad++; $display("FAIL rand_pop cyc %0d: got %b want %b", cyc, if4.pop, e_pop); end
            total++; if (if4.push !== e_push) begin bad++; $display("FAIL rand_push cyc %0d: got %b want %b", cyc, if4.push, e_push); end
            total++; if (if4.grant_valid !== m_gv || if4.grant_id !== m_gid) begin
                bad++; $display("FAIL rand_grant cyc %0d: got v=%b id=%0d want v=%b id=%0d", cyc, if4.grant_valid, if4.grant_id, m_gv, m_gid);
            end
            total++; if (if4.drop_cnt !== 8'(m_drop)) begin bad++; $display("FAIL rand_drop cyc %0d: got %0d want %0d", cyc, if4.drop_cnt, m_drop); end
            if (pick >= 0) begin
                m_cred[pick] = m_cred[pick] - 1;
                m_ptr = (m_cred[pick] != 0) ? pick : (pick + 1) % 4;
                m_gv = 1'b1; m_gid = 2'(pick);
            end else begin
                m_gv = 1'b0;
                if (!stall) begin
                    any_w = 1'b0;
                    for (int i = 0; i < 4; i++) if (!if4.empty_fifo[i] && w[i] > 0) any_w = 1'b1;
                    if (any_w) for (int i = 0; i < 4; i++) m_cred[i] = w[i];
                end
            end
            if (if4.demux_valid && e_push == 4'b0000 && m_drop < 255) m_drop++;
            @(negedge clk);
        end
        if4.active = 1'b1; if4.almost_full_fifo = 4'b0000; if4.demux_valid = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        if4.active = 1'b1; if4.weights = '0; if4.empty_fifo = 4'b1111;
        if4.almost_full_fifo = 4'b0000; if4.demux_in = '0; if4.demux_valid = 1'b0;
        if3.active = 1'b1; if3.weights = '0; if3.empty_fifo = 3'b111;
        if3.almost_full_fifo = 3'b000; if3.demux_in = '0; if3.demux_valid = 1'b0;

        test_reset();
        test_weighted_round();
        test_stall_hold();
        test_empty_refill();
        test_zero_weights();
        test_async_reset();
        test_drop_class();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arbitro_wrr.md
ARBITRO_WRR -- requirements
Module: arbitro_wrr

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of input FIFO channels, 2..16.
REQ-002 SHALL have parameter DATA_W, default 12: demux word width.
REQ-003 SHALL have parameter CLASS_LSB, default 8: LSB of the class field in demux_in, field width CW = clog2(NUM_CH).
REQ-004 SHALL have parameter WEIGHT_W, default 3: per-channel weight/credit width.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port active, input, 1: block enable; 0 gates all pop/push.
REQ-008 SHALL have port weights, input, NUM_CH*WEIGHT_W: weight of channel i at [i*WEIGHT_W +: WEIGHT_W]; 0 disables the channel.
REQ-009 SHALL have port empty_fifo, input, NUM_CH: input FIFO empty flags.
REQ-010 SHALL have port almost_full_fifo, input, NUM_CH: downstream FIFO almost-full flags.
REQ-011 SHALL have port demux_in, input, DATA_W: incoming word.
REQ-012 SHALL have port demux_valid, input, 1: demux_in valid this cycle.
REQ-013 SHALL have port pop, output, NUM_CH: one-hot or zero pop strobes to the input FIFOs.
REQ-014 SHALL have port push, output, NUM_CH: one-hot or zero push strobes to the input FIFOs.
REQ-015 SHALL have port grant_id, output, CW: channel popped in the previous cycle.
REQ-016 SHALL have port grant_valid, output, 1: grant_id is meaningful.
REQ-017 SHALL have port drop_cnt, output, 8: saturating count of refused valid words.

Function
REQ-018 SHALL define stall = !active | (|almost_full_fifo); when stall=1, pop=0 and credit, ptr and round state hold.
REQ-019 SHALL hold a credit[i] register per channel and a rotating pointer ptr (CW bits).
REQ-020 SHALL treat channel i as eligible when !empty_fifo[i] and credit[i]!=0.
REQ-021 SHALL, when not stalled, scan from ptr upward modulo NUM_CH and assert pop for the first eligible channel, combinationally in the same cycle.
REQ-022 SHALL, on a pop of channel i, decrement credit[i] at the clock edge and set ptr=i if credit[i]-1!=0, else ptr=(i+1) mod NUM_CH.
REQ-023 SHALL, when not stalled, with no eligible channel and at least one non-empty channel of nonzero weight, assert no pop, reload credit[i]=weights[i] for every i, and keep ptr (one bubble cycle).
REQ-024 SHALL, when all channels are empty or all non-empty channels have weight 0, assert no pop and change no state.
REQ-025 SHALL, when pop fires, register grant_id=i and grant_valid=1 one cycle later; otherwise grant_valid=0 and grant_id holds.
REQ-026 SHALL apply weight changes only at the next reload; in-flight credits are unaffected.
REQ-027 SHALL assert push[c] combinationally when demux_valid & !stall, where c = demux_in[CLASS_LSB +: CW] and c<NUM_CH.
REQ-028 SHALL increment drop_cnt, saturating at 255, on each cycle with demux_valid=1 and no push (stall, or class>=NUM_CH).
REQ-029 SHALL treat ptr wrap from NUM_CH-1 to 0 as ordinary modulo behaviour, including non-power-of-two NUM_CH.

Reset
REQ-030 SHALL, while reset=1, asynchronously force credit[*]=0, ptr=0, grant_id=0, grant_valid=0 and drop_cnt=0; pop and push SHALL be 0.
REQ-031 SHALL make its first non-stalled cycle after reset with non-empty weighted channels a reload bubble, per REQ-023.
REQ-032 SHALL, on reset asserted mid-round, discard the round with no partial credit retained.

Structure
REQ-033 SHALL place NUM_CH/DATA_W/WEIGHT_W defaults and the drop counter width constant in a shared package arbitro_pkg.
REQ-034 SHALL implement the rotating first-eligible search as sub-module rr_pick (inputs: request vector, ptr; outputs: found, index).

Verification
REQ-035 SHALL verify: weights 4,3,2,1, all non-empty, no stall -> bubble, then pops ch0 x4, ch1 x3, ch2 x2, ch3 x1, bubble, repeat.
REQ-036 SHALL verify: almost_full_fifo=0010 asserted after the second ch1 pop for 3 cycles -> pop=0 for those cycles, sequence then resumes with the third ch1 pop.
REQ-037 SHALL verify: ch1 empties after one pop with weights 4,3,2,1 -> ptr advances to ch2; ch1's remaining credit 2 is used if it refills before reload.
REQ-038 SHALL verify: NUM_CH=3, demux_valid with class 3 -> push=000 and drop_cnt increments; 300 stalled valids -> drop_cnt=255.
REQ-039 SHALL verify: reset asserted asynchronously mid-round -> outputs zero immediately, post-reset first active cycle is a bubble.
REQ-040 SHALL verify: weights 0,2,0,2 -> ch0 and ch2 never popped; alternating ch1 x2, ch3 x2 with bubbles between rounds.
